adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 140 ++++++++++++++
 tb/tb_adder_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined add/subtract built from 4-bit carry-lookahead groups.
// One WIDTH/STAGES-bit slice per stage, valid/ready with global stall.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SW  = WIDTH / STAGES;
  localparam int NG  = SW / 4;
  localparam int MSB = WIDTH - 1;

  function automatic logic [SW:0] cla_slice(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b,
    input logic          ci
  );
    logic [SW-1:0] p, g, s;
    logic [NG:0]   gc;
    logic [3:0]    pj, gj, c;
    logic          cj, gg;
    p = a ^ b;
    g = a & b;
    s = '0;
    gc = '0;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      pj = p[4*j +: 4];
      gj = g[4*j +: 4];
      cj = gc[j];
      c[0] = cj;
      c[1] = gj[0] | (pj[0] & cj);
      c[2] = gj[1] | (pj[1] & gj[0]) | (pj[1] & pj[0] & cj);
      c[3] = gj[2] | (pj[2] & gj[1]) | (pj[2] & pj[1] & gj[0])
           | (pj[2] & pj[1] & pj[0] & cj);
      gg = gj[3] | (pj[3] & gj[2]) | (pj[3] & pj[2] & gj[1])
         | (pj[3] & pj[2] & pj[1] & gj[0]);
      gc[j+1] = gg | ((&pj) & cj);
      s[4*j +: 4] = pj ^ c;
    end
    return {gc[NG], s};
  endfunction

  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             src_v [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [SW:0]      r     [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             en;
  logic [WIDTH-1:0] fin;

  always_comb begin
    en = !v_q[STAGES-1] || out_ready;
    src_v[0] = in_valid;
    src_a[0] = A;
    src_b[0] = sub ? ~B : B;
    src_c[0] = C ^ sub;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k] = cla_slice(src_a[k][k*SW +: SW],
                       src_b[k][k*SW +: SW],
                       src_c[k]);
      v_d[k] = src_v[k];
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
      c_d[k] = r[k][SW];
      s_d[k] = src_s[k];
      s_d[k][k*SW +: SW] = r[k][SW-1:0];
    end
    // flags come from the completed sum so they land with S
    fin = s_d[STAGES-1];
    ovf_d = (src_a[STAGES-1][MSB] == src_b[STAGES-1][MSB])
         && (fin[MSB] != src_a[STAGES-1][MSB]);
    zero_d = (fin == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign S         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed cases, 4-stage carry case,
// randomized traffic against an arithmetic reference pipeline.
module tb_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, C, sub;
  logic        out_valid, out_ready, cout, ovf, zero;
  logic [31:0] A, B, S;

  adder_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf), .zero(zero)
  );

  logic        v4, rdy4, ov4, co4, of4, z4;
  logic [31:0] a4, b4, s4;

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4),
    .A(a4), .B(b4), .C(1'b0), .sub(1'b0), .out_valid(ov4),
    .out_ready(1'b1), .S(s4), .cout(co4), .ovf(of4), .zero(z4)
  );

  typedef struct {
    logic        v;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  int   taken = 0;
  logic rnd = 1'b0;
  logic started = 1'b0;
  res_t pipe [2];
  res_t pin;

  function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic sb);
    res_t        o;
    logic [31:0] bp;
    logic [32:0] t;
    bp   = sb ? ~b : b;
    t    = {1'b0, a} + {1'b0, bp} + {32'd0, c ^ sb};
    o.v  = 1'b1;
    o.s  = t[31:0];
    o.co = t[32];
    o.ov = (a[31] == bp[31]) && (o.s[31] != a[31]);
    o.z  = (o.s == 32'd0);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference pipeline: STAGES slots advancing on the global enable
  always @(posedge clk) begin
    if (rst) begin
      started   <= 1'b1;
      pipe[0].v <= 1'b0;
      pipe[1].v <= 1'b0;
    end else if (!pipe[1].v || out_ready) begin
      pipe[1] <= pipe[0];
      if (in_valid) begin
        pipe[0] <= ref_add(A, B, C, sub);
        if (rnd) accepted <= accepted + 1;
      end else begin
        pipe[0].v <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, pipe[1].v});
      chk("in_ready", {63'd0, in_ready},
          {63'd0, (!pipe[1].v || out_ready)});
      if (pipe[1].v) begin
        chk("S", {32'd0, S}, {32'd0, pipe[1].s});
        chk("cout", {63'd0, cout}, {63'd0, pipe[1].co});
        chk("ovf", {63'd0, ovf}, {63'd0, pipe[1].ov});
        chk("zero", {63'd0, zero}, {63'd0, pipe[1].z});
      end
      if (rnd && out_valid && out_ready) taken <= taken + 1;
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic sb);
    in_valid = 1'b1;
    A = a;
    B = b;
    C = c;
    sub = sb;
  endtask

  function automatic logic [31:0] pick();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    C = 1'b0;
    sub = 1'b0;
    v4 = 1'b0;
    a4 = '0;
    b4 = '0;

    pin = ref_add(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_ff_s", {32'd0, pin.s}, 64'h0);
    chk("model_ff_co", {63'd0, pin.co}, 64'h1);
    pin = ref_add(32'h5, 32'h7, 1'b1, 1'b1);
    chk("model_borrow_s", {32'd0, pin.s}, 64'hFFFF_FFFD);
    pin = ref_add(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_ovf", {63'd0, pin.ov}, 64'h1);

    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'h0);
    chk("rst_S", {32'd0, S}, 64'h0);
    chk("rst_flags", {61'd0, cout, ovf, zero}, 64'h0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'h1);
    rst = 1'b0;

    drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lat_not_early", {63'd0, out_valid}, 64'h0);
    step();
    chk("wrap_valid", {63'd0, out_valid}, 64'h1);
    chk("wrap_S", {32'd0, S}, 64'h0);
    chk("wrap_flags", {61'd0, cout, ovf, zero}, 64'h5);

    drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    step();
    drive(32'h5, 32'h7, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ovf_S", {32'd0, S}, 64'h8000_0000);
    chk("ovf_flags", {61'd0, cout, ovf, zero}, 64'h2);
    step();
    chk("sub_S", {32'd0, S}, 64'hFFFF_FFFE);
    chk("sub_flags", {61'd0, cout, ovf, zero}, 64'h0);
    step();

    a4 = 32'h0000_FFFF;
    b4 = 32'h1;
    v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s4_latency", {63'd0, ov4}, 64'h0);
      step();
    end
    chk("s4_valid", {63'd0, ov4}, 64'h1);
    chk("s4_S", {32'd0, s4}, 64'h0001_0000);

    drive(32'h1, 32'h1, 1'b0, 1'b0);
    step();
    drive(32'h2, 32'h2, 1'b0, 1'b0);
    step();
    drive(32'h3, 32'h3, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {63'd0, in_ready}, 64'h0);
      chk("stall_S", {32'd0, S}, 64'h2);
      step();
    end
    chk("stall_hold_valid", {63'd0, out_valid}, 64'h1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bb_S4", {32'd0, S}, 64'h4);
    step();
    chk("bb_S6", {32'd0, S}, 64'h6);
    step();
    chk("bb_drained", {63'd0, out_valid}, 64'h0);

    drive(32'h9, 32'h9, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive(32'h11, 32'h22, 1'b0, 1'b0);
    step();
    chk("flush_valid", {63'd0, out_valid}, 64'h0);
    chk("flush_S", {32'd0, S}, 64'h0);
    chk("flush_flags", {61'd0, cout, ovf, zero}, 64'h0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'h1);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_discard", {63'd0, out_valid}, 64'h0);
    drive(32'h3, 32'h4, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_valid", {63'd0, out_valid}, 64'h1);
    chk("post_rst_S", {32'd0, S}, 64'h7);
    step();

    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = pick();
      B         = pick();
      C         = $urandom_range(0, 1) == 1;
      sub       = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rnd = 1'b0;
    chk("no_loss_dup", 64'(taken), 64'(accepted));
    chk("drained", {63'd0, out_valid}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
